bus_target_memory: RTL
======================

Name: bus_target_memory

Overview:
- Memory-mapped bus responder (target) for the shared transaction bus; the counterpart of the DMA/bus initiators.
- Decodes transactions addressed to its window, accepts single/burst writes into a local word RAM, and returns single/burst reads.
- Local RAM is also exposed read-only to a local core.
- All bus outputs are zero when not driving, so they can be OR-combined with other targets.

Parameters:
- Base, 32'h40000000, byte base address of window (aligned to window size)
- AddrBits, 9, log2 of RAM depth in 32-bit words; window = 4*2^AddrBits bytes

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- address_dataIN  in  32  address in begin cycle, write data in data beats
- byte_enableIN  in  4  byte lanes, sampled in begin cycle
- burst_sizeIN  in  8  beats minus 1, sampled in begin cycle
- read_n_writeIN  in  1  1=read, 0=write, sampled in begin cycle
- begin_transactionIN  in  1  transaction start strobe
- end_transactionIN  in  1  initiator ends write / aborts
- data_validIN  in  1  write beat valid
- busyIN  in  1  initiator stalls read beats
- errorIN  in  1  bus error, aborts all
- address_dataOUT  out  32  read data
- end_transactionOUT  out  1  read transaction complete
- data_validOUT  out  1  read beat valid
- busyOUT  out  1  target stall; constant 0 in this block
- errorOUT  out  1  target error strobe
- local_address  in  AddrBits  local-core read address
- local_data  out  32  RAM word at local_address, 1-cycle latency
- write_done  out  1  one-cycle pulse when a write transaction ends

Behaviour:
- Reset, asynchronous active-low: state=IDLE, all counters/latches 0. All outputs 0, including local_data.
- Hit: begin_transactionIN=1 and Base <= address_dataIN < Base + 4*2^AddrBits. Non-hits are ignored entirely; no output changes.
- On a hit in IDLE, latch:
  - word index = address_dataIN[AddrBits+1:2]
  - remaining beat count = burst_sizeIN
  - byte_enableIN and read_n_writeIN
- If address_dataIN[1:0] != 0 on a hit, go to ERR instead.
- Begin while not IDLE is ignored.
- States:
  - IDLE: wait for a hit. Write -> WR; read -> RD_FETCH.
  - WR: accepts a beat in any cycle with data_validIN=1. RAM bytes with byte_enable=1 are written at the word index; the index increments. Beats after burst_size+1 accepted beats are dropped. end_transactionIN=1 -> WDONE; a beat valid in the same cycle is still written.
  - WDONE: write_done=1 for one cycle -> IDLE.
  - RD_FETCH: RAM read address = word index (registered read, 1 cycle) -> RD_DATA.
  - RD_DATA: data_validOUT=1; address_dataOUT = RAM data with disabled byte lanes forced to 0.
    - busyIN=1: stay, data held stable (RAM address held).
    - busyIN=0 and count=0 -> RD_END.
    - busyIN=0 and count>0: index+1, count-1 -> RD_FETCH.
  - RD_END: end_transactionOUT=1 for one cycle -> IDLE.
  - ERR: errorOUT=1 for one cycle -> IDLE.
- errorIN=1 in any state: next state IDLE, no further RAM writes. The write in that same cycle is suppressed.
- end_transactionIN=1 during RD_FETCH/RD_DATA: abort to IDLE, no RD_END.
- Word index wraps modulo 2^AddrBits; bursts wrap inside the window, never beyond it.
- Read timing: begin in cycle T gives beat k (k=0..N-1) at T+2+2k with no stalls; end_transactionOUT at T+2N+1.
- Write timing: beat data is visible on local_data 2 cycles after its accept cycle (1 cycle write + 1 cycle read).
- RAM: single write port (bus) plus two read ports (bus, local). The local read port is independent of the FSM.

Decomposition:
- Shared package: FSM state encodings (IDLE, WR, WDONE, RD_FETCH, RD_DATA, RD_END, ERR) and the bus byte-lane width constant (4). The bus initiator blocks reuse these.
- One natural sub-module: bus_target_ram, a 2^AddrBits x 32 synchronous RAM with per-byte write enables and two registered read ports.

Test Plan:
- Single write, then read: write 0xDEADBEEF to 0x40000010 with be=4'hF, burst=0. Read it back -> data_validOUT at T+2 with 0xDEADBEEF; end_transactionOUT at T+3; write_done pulse one cycle after end_transactionIN.
- Byte-enable burst: burst write of 4 beats 0x11111111..0x44444444 to 0x40000000 with be=4'h3. Local read of index 0..3 -> 0x00001111..0x00004444.
- Read stall: 3-beat read with busyIN high for 3 cycles on beat 1 -> beat 1 data held stable and valid for 4 cycles; 3 beats total; one end_transactionOUT.
- Decode/error: begin at 0x3FFFFFFC or 0x40000800 -> no response. Begin at 0x40000002 -> errorOUT pulse at T+1, then IDLE.
- Wrap: 2-beat write starting at 0x400007FC -> words 511 and 0 written.
- Reset mid-burst: reset low during RD_DATA -> all outputs 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/bus_target_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_memory_pkg
// Description : Shared definitions for the transaction-bus target and the bus
//               initiators: FSM state encoding, byte-lane width and a helper
//               that expands byte enables into a 32-bit lane mask.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_target_memory_pkg;

    localparam int BUS_LANES  = 4;
    localparam int BUS_DATA_W = 8 * BUS_LANES;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WDONE    = 3'd2,
        ST_RD_FETCH = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_RD_END   = 3'd5,
        ST_ERR      = 3'd6
    } bus_state_e;

    // Expand per-byte enables into a full data-width mask.
    function automatic logic [BUS_DATA_W-1:0] lane_mask(input logic [BUS_LANES-1:0] be);
        logic [BUS_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BUS_LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_target_ram.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_ram
// Description : 2^AddrBits x 32 synchronous RAM, one write port with per-byte
//               enables and two independent registered read ports.
//               Reads return the contents before a same-edge write.
// Ports       : clock, reset        - clock / async active-low reset (read regs)
//               wr_en_i[3:0]        - per-byte write enables
//               wr_addr_i, wr_data_i- write word address / data
//               rd_addr_a_i/rd_data_a_o - read port A (bus side)
//               rd_addr_b_i/rd_data_b_o - read port B (local core side)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_target_ram
    import bus_target_memory_pkg::*;
#(
    parameter int AddrBits = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BUS_LANES-1:0]  wr_en_i,
    input  logic [AddrBits-1:0]   wr_addr_i,
    input  logic [BUS_DATA_W-1:0] wr_data_i,
    input  logic [AddrBits-1:0]   rd_addr_a_i,
    output logic [BUS_DATA_W-1:0] rd_data_a_o,
    input  logic [AddrBits-1:0]   rd_addr_b_i,
    output logic [BUS_DATA_W-1:0] rd_data_b_o
);

    localparam int DEPTH = 1 << AddrBits;

    logic [BUS_DATA_W-1:0] mem_q [DEPTH];
    logic [BUS_DATA_W-1:0] rd_a_q;
    logic [BUS_DATA_W-1:0] rd_b_q;

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clock) begin
        for (int i = 0; i < BUS_LANES; i++) begin
            if (wr_en_i[i]) begin
                mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= mem_q[rd_addr_a_i];
            rd_b_q <= mem_q[rd_addr_b_i];
        end
    end

    assign rd_data_a_o = rd_a_q;
    assign rd_data_b_o = rd_b_q;

endmodule
`default_nettype wire

// File: rtl/bus_target_memory.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_memory
// Description : Memory-mapped target on the shared transaction bus. Decodes
//               its address window, accepts single/burst writes into a local
//               word RAM and returns single/burst reads. The RAM is also
//               readable by the local core through an independent port.
//               Bus outputs are zero whenever the target is not driving so
//               they can be OR-combined with other targets.
// Ports       : clock, reset (async, active-low)
//               address_dataIN/byte_enableIN/burst_sizeIN/read_n_writeIN,
//               begin_transactionIN, end_transactionIN, data_validIN,
//               busyIN, errorIN                       - bus inputs
//               address_dataOUT, end_transactionOUT, data_validOUT,
//               busyOUT, errorOUT                     - bus outputs
//               local_address / local_data            - local read port
//               write_done                            - write-end pulse
// Revision    : 1.0 - initial release
// ============================================================================
module bus_target_memory
    import bus_target_memory_pkg::*;
#(
    parameter logic [31:0] Base     = 32'h40000000,
    parameter int          AddrBits = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         address_dataIN,
    input  logic [3:0]          byte_enableIN,
    input  logic [7:0]          burst_sizeIN,
    input  logic                read_n_writeIN,
    input  logic                begin_transactionIN,
    input  logic                end_transactionIN,
    input  logic                data_validIN,
    input  logic                busyIN,
    input  logic                errorIN,
    output logic [31:0]         address_dataOUT,
    output logic                end_transactionOUT,
    output logic                data_validOUT,
    output logic                busyOUT,
    output logic                errorOUT,
    input  logic [AddrBits-1:0] local_address,
    output logic [31:0]         local_data,
    output logic                write_done
);

    localparam logic [AddrBits-1:0] IDX_ONE = {{(AddrBits-1){1'b0}}, 1'b1};

    bus_state_e             state_q, state_d;
    logic [AddrBits-1:0]    index_q, index_d;
    logic [7:0]             count_q, count_d;
    logic [3:0]             be_q, be_d;
    logic                   full_q, full_d;   // write burst has taken all its beats
    logic                   data_valid_q;
    logic                   end_q;
    logic                   error_q;
    logic                   write_done_q;

    logic                   hit;
    logic                   wr_accept;
    logic [31:0]            bus_rdata;

    // Window is aligned to its size, so comparing the upper address bits
    // is equivalent to the range check.
    assign hit = begin_transactionIN &&
                 (address_dataIN[31:AddrBits+2] == Base[31:AddrBits+2]);

    assign wr_accept = (state_q == ST_WR) && data_validIN && !full_q && !errorIN;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        be_d    = be_q;
        full_d  = full_q;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    index_d = address_dataIN[AddrBits+1:2];
                    count_d = burst_sizeIN;
                    be_d    = byte_enableIN;
                    full_d  = 1'b0;
                    if (address_dataIN[1:0] != 2'b00) begin
                        state_d = ST_ERR;
                    end else if (read_n_writeIN) begin
                        state_d = ST_RD_FETCH;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (wr_accept) begin
                    index_d = index_q + IDX_ONE;
                    if (count_q == 8'd0) begin
                        full_d = 1'b1;
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end
                if (end_transactionIN) begin
                    state_d = ST_WDONE;
                end
            end
            ST_WDONE: state_d = ST_IDLE;
            ST_RD_FETCH: begin
                state_d = end_transactionIN ? ST_IDLE : ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (end_transactionIN) begin
                    state_d = ST_IDLE;
                end else if (!busyIN) begin
                    if (count_q == 8'd0) begin
                        state_d = ST_RD_END;
                    end else begin
                        index_d = index_q + IDX_ONE;
                        count_d = count_q - 8'd1;
                        state_d = ST_RD_FETCH;
                    end
                end
            end
            ST_RD_END: state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (errorIN) begin
            state_d = ST_IDLE;
        end
    end

    // Bus-facing strobes are registered, decoded from the next state so they
    // are asserted for exactly the cycles spent in the matching state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            count_q      <= '0;
            be_q         <= '0;
            full_q       <= 1'b0;
            data_valid_q <= 1'b0;
            end_q        <= 1'b0;
            error_q      <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            count_q      <= count_d;
            be_q         <= be_d;
            full_q       <= full_d;
            data_valid_q <= (state_d == ST_RD_DATA);
            end_q        <= (state_d == ST_RD_END);
            error_q      <= (state_d == ST_ERR);
            write_done_q <= (state_d == ST_WDONE);
        end
    end

    // Bus read port always follows the current word index; holding the index
    // during a stall keeps the returned data stable.
    bus_target_ram #(
        .AddrBits (AddrBits)
    ) u_ram (
        .clock       (clock),
        .reset       (reset),
        .wr_en_i     (wr_accept ? be_q : 4'b0000),
        .wr_addr_i   (index_q),
        .wr_data_i   (address_dataIN),
        .rd_addr_a_i (index_q),
        .rd_data_a_o (bus_rdata),
        .rd_addr_b_i (local_address),
        .rd_data_b_o (local_data)
    );

    assign address_dataOUT    = data_valid_q ? (bus_rdata & lane_mask(be_q)) : 32'h0;
    assign data_validOUT      = data_valid_q;
    assign end_transactionOUT = end_q;
    assign errorOUT           = error_q;
    assign write_done         = write_done_q;
    assign busyOUT            = 1'b0;

endmodule
`default_nettype wire
